// File: rtl/alu_mdu.sv
// Execute-stage ALU with an iterative multiply/divide unit producing {HI,LO}.
// Optional macro ALU_FAST_MUL_EN: MULT/MULTU complete via a single-cycle multiplier.
module alu_mdu #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     alu_num1,
  input  logic [WIDTH-1:0]     alu_num2,
  input  logic [7:0]           alucontrol,
  input  logic                 valid_in,
  input  logic                 flush,
  output logic [WIDTH-1:0]     alu_out,
  output logic                 overflow,
  output logic                 zero,
  output logic [2*WIDTH-1:0]   hilo_out,
  output logic                 hilo_valid,
  output logic                 stall
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [SW-1:0] CNT_LAST = SW'(WIDTH - 1);

  localparam logic [7:0] OP_AND   = 8'b0010_0100, OP_OR    = 8'b0010_0101;
  localparam logic [7:0] OP_XOR   = 8'b0010_0110, OP_NOR   = 8'b0010_0111;
  localparam logic [7:0] OP_ANDI  = 8'b0101_1001, OP_ORI   = 8'b0101_1010;
  localparam logic [7:0] OP_XORI  = 8'b0101_1011, OP_LUI   = 8'b0101_1100;
  localparam logic [7:0] OP_SLLV  = 8'b0000_0100, OP_SRLV  = 8'b0000_0110;
  localparam logic [7:0] OP_SRAV  = 8'b0000_0111, OP_SLT   = 8'b0010_1010;
  localparam logic [7:0] OP_SLTU  = 8'b0010_1011, OP_SLTI  = 8'b0101_0111;
  localparam logic [7:0] OP_SLTIU = 8'b0101_1000, OP_ADD   = 8'b0010_0000;
  localparam logic [7:0] OP_ADDU  = 8'b0010_0001, OP_SUB   = 8'b0010_0010;
  localparam logic [7:0] OP_SUBU  = 8'b0010_0011, OP_ADDI  = 8'b0101_0101;
  localparam logic [7:0] OP_ADDIU = 8'b0101_0110, OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] OP_MULTU = 8'b0001_1001, OP_DIV   = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU  = 8'b0001_1011, OP_J     = 8'b0100_1111;
  localparam logic [7:0] OP_BEQ   = 8'b0101_0001, OP_BNE   = 8'b0101_0010;
  localparam logic [7:0] OP_LB    = 8'b1110_0000, OP_LBU   = 8'b1110_0100;
  localparam logic [7:0] OP_LH    = 8'b1110_0001, OP_LHU   = 8'b1110_0101;
  localparam logic [7:0] OP_LW    = 8'b1110_0011, OP_SB    = 8'b1110_1000;
  localparam logic [7:0] OP_SH    = 8'b1110_1001, OP_SW    = 8'b1110_1011;
  localparam logic [7:0] OP_MTC0  = 8'b0110_0000;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

  state_t               state, state_next;
  logic [SW-1:0]        cnt;
  logic [WIDTH-1:0]     mcand, num1_q;
  logic [2*WIDTH-1:0]   acc, step;
  logic                 is_div_q, res_neg, rem_neg, div_zero;

  logic                 is_mult, is_div, is_signed, sign_a, sign_b, accept;
  logic [WIDTH-1:0]     a_mag, b_mag, sum, diff, ext16, div_diff;
  logic [WIDTH:0]       mul_sum, div_shift;
  logic [2*WIDTH-1:0]   fast_prod;

  // Sign-correct a raw magnitude result into the architectural {HI,LO} pair.
  function automatic logic [2*WIDTH-1:0] fix_hilo(
    input logic [2*WIDTH-1:0] raw,
    input logic               div_op,
    input logic               neg_q,
    input logic               neg_r,
    input logic               dz,
    input logic [WIDTH-1:0]   dividend
  );
    logic [WIDTH-1:0] hi, lo;
    if (div_op) begin
      hi = neg_r ? -raw[2*WIDTH-1:WIDTH] : raw[2*WIDTH-1:WIDTH];
      lo = neg_q ? -raw[WIDTH-1:0] : raw[WIDTH-1:0];
      fix_hilo = dz ? {dividend, {WIDTH{1'b1}}} : {hi, lo};
    end else begin
      fix_hilo = neg_q ? -raw : raw;
    end
  endfunction

  assign is_mult   = (alucontrol == OP_MULT) || (alucontrol == OP_MULTU);
  assign is_div    = (alucontrol == OP_DIV)  || (alucontrol == OP_DIVU);
  assign is_signed = (alucontrol == OP_MULT) || (alucontrol == OP_DIV);
  assign sign_a    = is_signed & alu_num1[WIDTH-1];
  assign sign_b    = is_signed & alu_num2[WIDTH-1];
  assign a_mag     = sign_a ? -alu_num1 : alu_num1;
  assign b_mag     = sign_b ? -alu_num2 : alu_num2;
  assign accept    = valid_in & (is_mult | is_div) & ~flush;
  assign fast_prod = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};

  assign sum   = alu_num1 + alu_num2;
  assign diff  = alu_num1 - alu_num2;
  assign ext16 = {{(WIDTH-16){1'b0}}, alu_num2[15:0]};

  // Single-cycle result and signed overflow.
  always_comb begin
    alu_out  = {WIDTH{1'b0}};
    overflow = 1'b0;
    case (alucontrol)
      OP_AND:  alu_out = alu_num1 & alu_num2;
      OP_OR:   alu_out = alu_num1 | alu_num2;
      OP_XOR:  alu_out = alu_num1 ^ alu_num2;
      OP_NOR:  alu_out = ~(alu_num1 | alu_num2);
      OP_ANDI: alu_out = alu_num1 & ext16;
      OP_ORI:  alu_out = alu_num1 | ext16;
      OP_XORI: alu_out = alu_num1 ^ ext16;
      OP_LUI:  alu_out = ext16 << 16;
      OP_SLLV: alu_out = alu_num2 << alu_num1[SW-1:0];
      OP_SRLV: alu_out = alu_num2 >> alu_num1[SW-1:0];
      OP_SRAV: alu_out = $signed(alu_num2) >>> alu_num1[SW-1:0];
      OP_SLT, OP_SLTI:
        alu_out = {{(WIDTH-1){1'b0}}, $signed(alu_num1) < $signed(alu_num2)};
      OP_SLTU, OP_SLTIU:
        alu_out = {{(WIDTH-1){1'b0}}, alu_num1 < alu_num2};
      OP_ADD, OP_ADDI: begin
        alu_out  = sum;
        overflow = (alu_num1[WIDTH-1] == alu_num2[WIDTH-1]) && (sum[WIDTH-1] != alu_num1[WIDTH-1]);
      end
      OP_ADDU, OP_ADDIU, OP_J, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW:
        alu_out = sum;
      OP_SUB: begin
        alu_out  = diff;
        overflow = (alu_num1[WIDTH-1] != alu_num2[WIDTH-1]) && (diff[WIDTH-1] != alu_num1[WIDTH-1]);
      end
      OP_SUBU, OP_BEQ, OP_BNE: alu_out = diff;
      OP_MTC0: alu_out = alu_num2;
      default: alu_out = {WIDTH{1'b0}};
    endcase
  end

  assign zero = (alu_out == {WIDTH{1'b0}});

  // One shift-add (mul) or restoring shift-subtract (div) iteration.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift[WIDTH-1:0] - mcand;
    if (!is_div_q) begin
      step = {mul_sum, acc[WIDTH-1:1]};
    end else if (div_shift >= {1'b0, mcand}) begin
      step = {div_diff, acc[WIDTH-2:0], 1'b1};
    end else begin
      step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // FSM next-state logic; flush has priority over progress and accept.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
`ifdef ALU_FAST_MUL_EN
          state_next = is_mult ? S_DONE : S_BUSY;
`else
          state_next = S_BUSY;
`endif
        end else begin
          state_next = S_IDLE;
        end
      end
      S_BUSY: begin
        if (flush)              state_next = S_IDLE;
        else if (cnt == CNT_LAST) state_next = S_DONE;
        else                    state_next = S_BUSY;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM output: hold the pipeline from the accept cycle through BUSY.
  always_comb begin
    if (rst) stall = 1'b0;
    else     stall = (state == S_BUSY) || ((state == S_IDLE) && accept);
  end

  // Operand capture, iteration state and registered {HI,LO} result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0; mcand <= '0; num1_q <= '0; acc <= '0;
      is_div_q <= 1'b0; res_neg <= 1'b0; rem_neg <= 1'b0; div_zero <= 1'b0;
      hilo_out <= '0; hilo_valid <= 1'b0;
    end else begin
      hilo_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            cnt      <= '0;
            mcand    <= b_mag;
            acc      <= {{WIDTH{1'b0}}, a_mag};
            num1_q   <= alu_num1;
            is_div_q <= is_div;
            res_neg  <= sign_a ^ sign_b;
            rem_neg  <= sign_a;
            div_zero <= (alu_num2 == {WIDTH{1'b0}});
`ifdef ALU_FAST_MUL_EN
            if (is_mult) begin
              hilo_out   <= fix_hilo(fast_prod, 1'b0, sign_a ^ sign_b, 1'b0, 1'b0, alu_num1);
              hilo_valid <= 1'b1;
            end
`endif
          end
        end
        S_BUSY: begin
          if (!flush) begin
            acc <= step;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              hilo_out   <= fix_hilo(step, is_div_q, res_neg, rem_neg, div_zero, num1_q);
              hilo_valid <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed self-checking bench for alu_mdu (WIDTH = 32), honours ALU_FAST_MUL_EN.
module tb_alu_mdu;
  localparam int W = 32;
  localparam logic [7:0] OP_NOR = 8'b0010_0111, OP_ORI = 8'b0101_1010, OP_LUI = 8'b0101_1100;
  localparam logic [7:0] OP_SRAV = 8'b0000_0111, OP_SLT = 8'b0010_1010, OP_SLTU = 8'b0010_1011;
  localparam logic [7:0] OP_ADD = 8'b0010_0000, OP_ADDU = 8'b0010_0001, OP_SUB = 8'b0010_0010;
  localparam logic [7:0] OP_MULT = 8'b0001_1000, OP_MULTU = 8'b0001_1001;
  localparam logic [7:0] OP_DIV = 8'b0001_1010, OP_DIVU = 8'b0001_1011;
  localparam logic [7:0] OP_MTC0 = 8'b0110_0000, OP_ERET = 8'b0110_1011, OP_LW = 8'b1110_0011;
`ifdef ALU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W + 1;
`endif
  localparam int DIV_LAT = W + 1;

  logic clk = 1'b0, rst = 1'b1, valid_in = 1'b0, flush = 1'b0;
  logic [W-1:0] alu_num1 = '0, alu_num2 = '0;
  logic [7:0] alucontrol = 8'h00;
  logic [W-1:0] alu_out;
  logic overflow, zero, hilo_valid, stall;
  logic [2*W-1:0] hilo_out;
  int n_cmp = 0, n_err = 0;

  alu_mdu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .alu_num1(alu_num1), .alu_num2(alu_num2),
    .alucontrol(alucontrol), .valid_in(valid_in), .flush(flush),
    .alu_out(alu_out), .overflow(overflow), .zero(zero),
    .hilo_out(hilo_out), .hilo_valid(hilo_valid), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input string tag, input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] exp_out, input logic exp_ov);
    alucontrol = op; alu_num1 = a; alu_num2 = b;
    #1;
    check({tag, ".out"}, alu_out, exp_out);
    check({tag, ".ov"}, overflow, exp_ov);
    check({tag, ".zero"}, zero, exp_out == '0);
  endtask

  // Issue in cycle 0, wait (bounded) for stall to drop, check latency and result.
  task automatic md(input string tag, input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic [2*W-1:0] exp, input int lat);
    int n;
    alucontrol = op; alu_num1 = a; alu_num2 = b; valid_in = 1'b1;
    #1;
    check({tag, ".stall0"}, stall, 1'b1);
    tick();
    valid_in = 1'b0; alucontrol = OP_ADDU;
    n = 1;
    while (stall === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check({tag, ".lat"}, n, lat);
    check({tag, ".valid"}, hilo_valid, 1'b1);
    check({tag, ".hilo"}, hilo_out, exp);
    tick();
    check({tag, ".pulse"}, hilo_valid, 1'b0);
  endtask

  initial begin
    int highs;
    tick(); tick();
    check("rst.stall", stall, 1'b0);
    check("rst.valid", hilo_valid, 1'b0);
    check("rst.hilo", hilo_out, 64'h0);
    rst = 1'b0;
    tick();

    alu("add_ovf",  OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1);
    alu("addu",     OP_ADDU, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0);
    alu("sub_ovf",  OP_SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1);
    alu("sub_zero", OP_SUB,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0);
    alu("srav",     OP_SRAV, 32'd35,        32'h8000_0000, 32'hF000_0000, 1'b0);
    alu("slt",      OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0);
    alu("sltu",     OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0);
    alu("lui",      OP_LUI,  32'h0000_0000, 32'h1234_ABCD, 32'hABCD_0000, 1'b0);
    alu("ori",      OP_ORI,  32'hF000_0000, 32'hFFFF_1234, 32'hF000_1234, 1'b0);
    alu("nor",      OP_NOR,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0);
    alu("lw",       OP_LW,   32'h0000_1000, 32'hFFFF_FFFC, 32'h0000_0FFC, 1'b0);
    alu("mtc0",     OP_MTC0, 32'h1111_1111, 32'hCAFE_0001, 32'hCAFE_0001, 1'b0);
    alu("eret",     OP_ERET, 32'h1111_1111, 32'h2222_2222, 32'h0000_0000, 1'b0);

    md("mult",     OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA, MUL_LAT);
    md("multu",    OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, MUL_LAT);
    md("div_neg",  OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, DIV_LAT);
    md("div_negb", OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, DIV_LAT);
    md("div_min",  OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, DIV_LAT);
    md("div_z",    OP_DIV,   32'hFFFF_FFFB, 32'h0000_0000, 64'hFFFF_FFFB_FFFF_FFFF, DIV_LAT);
    md("divu_z",   OP_DIVU,  32'h0000_0007, 32'h0000_0000, 64'h0000_0007_FFFF_FFFF, DIV_LAT);

    // Flush DIVU 100/7 in cycle 10; a fresh DIVU in cycle 12 must complete.
    alucontrol = OP_DIVU; alu_num1 = 32'd100; alu_num2 = 32'd7; valid_in = 1'b1;
    tick();
    valid_in = 1'b0; alucontrol = OP_ADDU;
    for (int c = 1; c < 10; c++) tick();
    flush = 1'b1;
    #1;
    check("flush.stall10", stall, 1'b1);
    tick();
    flush = 1'b0;
    check("flush.stall11", stall, 1'b0);
    check("flush.valid11", hilo_valid, 1'b0);
    check("flush.hilo11", hilo_out, 64'h0000_0007_FFFF_FFFF);
    tick();
    md("divu_after", OP_DIVU, 32'd100, 32'd7, 64'h0000_0002_0000_000E, DIV_LAT);

    // Flush in the accept cycle cancels the accept.
    alucontrol = OP_DIVU; alu_num1 = 32'd9; alu_num2 = 32'd2; valid_in = 1'b1; flush = 1'b1;
    #1;
    check("flacc.stall0", stall, 1'b0);
    tick();
    valid_in = 1'b0; flush = 1'b0;
    highs = 0;
    for (int c = 0; c < W + 3; c++) begin
      if (stall === 1'b1 || hilo_valid === 1'b1) highs++;
      tick();
    end
    check("flacc.quiet", highs, 0);
    check("flacc.hilo", hilo_out, 64'h0000_0002_0000_000E);

    // Asynchronous reset in cycle 5 of a MULT.
    alucontrol = OP_MULT; alu_num1 = 32'd6; alu_num2 = 32'd7; valid_in = 1'b1;
    tick();
    valid_in = 1'b0; alucontrol = OP_ADDU;
    for (int c = 1; c < 5; c++) tick();
    #2 rst = 1'b1;
    #1;
    check("arst.stall", stall, 1'b0);
    check("arst.valid", hilo_valid, 1'b0);
    check("arst.hilo", hilo_out, 64'h0);
    rst = 1'b0;
    tick();
    check("arst.idle", stall, 1'b0);
    md("mult_post", OP_MULT, 32'h0000_0006, 32'hFFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFD6, MUL_LAT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
